// File: rtl/des_round_sched.sv
// Iterative DES round controller: sequences load, ROUNDS round iterations
// and the final swap/inverse-IP latch, drives the key-schedule rotate
// controls, and hands the result off over a valid/ready pair.
// All outputs decode from registered state only, so no input reaches a
// strobe combinationally.
`timescale 1ns/1ps
module des_round_sched #(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_decrypt,
  input  logic             abort,
  output logic             load_en,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic [1:0]       rot_amt,
  output logic             rot_right,
  output logic             final_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             mode_q;   // 1 = decrypt, captured at accept

  // Left-rotate schedule for encryption.
  function automatic logic [1:0] enc_amt(input int idx);
    case (idx)
      0, 1, 8, 15: enc_amt = 2'd1;
      default:     enc_amt = 2'd2;
    endcase
  endfunction

  // Right-rotate schedule for decryption: the first round needs no
  // rotation because C/D after PC-1 already equals C16/D16.
  function automatic logic [1:0] dec_amt(input int idx);
    case (idx)
      0:          dec_amt = 2'd0;
      1, 8, 15:   dec_amt = 2'd1;
      default:    dec_amt = 2'd2;
    endcase
  endfunction

  // Control FSM with round counter and mode register; abort wins over
  // every other transition once an operation is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mode_q  <= in_decrypt;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          idx_q   <= '0;
          state_q <= abort ? S_IDLE : S_ROUND;
        end
        S_ROUND: begin
          if (abort) begin
            idx_q   <= '0;
            state_q <= S_IDLE;
          end else if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= S_FINAL;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_FINAL: begin
          state_q <= abort ? S_IDLE : S_DONE;
        end
        S_DONE: begin
          if (abort || out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state, counter and mode.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    load_en   = (state_q == S_LOAD);
    round_en  = (state_q == S_ROUND);
    final_en  = (state_q == S_FINAL);
    out_valid = (state_q == S_DONE);
    round_idx = idx_q;
    rot_right = 1'b0;
    rot_amt   = 2'd0;
    if (state_q == S_ROUND) begin
      rot_right = mode_q;
      rot_amt   = mode_q ? dec_amt(int'(idx_q)) : enc_amt(int'(idx_q));
    end
  end

endmodule

// File: tb/tb_des_round_sched.sv
// Directed bench for des_round_sched: table-driven full encrypt/decrypt
// runs plus hand sequences for backpressure, abort, async reset and
// back-to-back throughput.
`timescale 1ns/1ps
module tb_des_round_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_decrypt, abort;
  logic       load_en, round_en, rot_right, final_en, out_valid, out_ready, busy;
  logic [3:0] round_idx;
  logic [1:0] rot_amt;

  int errors = 0;
  int checks = 0;

  des_round_sched #(.ROUNDS(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
    .abort(abort),
    .load_en(load_en), .round_en(round_en), .round_idx(round_idx),
    .rot_amt(rot_amt), .rot_right(rot_right), .final_en(final_en),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observed outputs packed: ld rd fi ov ir bz rr ra[1:0] ix[3:0]
  logic [12:0] obs;
  assign obs = {load_en, round_en, final_en, out_valid, in_ready, busy,
                rot_right, rot_amt, round_idx};

  function automatic logic [12:0] mk(input logic ld, rd, fi, ov, ir, bz, rr,
                                     input logic [1:0] ra, input logic [3:0] ix);
    return {ld, rd, fi, ov, ir, bz, rr, ra, ix};
  endfunction

  logic [12:0] idle_p, load_p, done_p;
  logic [1:0]  enc_t [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                              2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  logic [1:0]  dec_t [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                              2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  typedef struct {
    logic        iv;
    logic        dec;
    logic        ab;
    logic        ordy;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl [42];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the edge and check strobe rules.
  task automatic step();
    @(posedge clk);
    #1;
    checks++;
    if (!$onehot0({load_en, round_en, final_en}) ||
        (!round_en && (rot_amt != 2'd0 || rot_right))) begin
      errors++;
      $display("FAIL excl at %0t: got strobes %b rot %0d/%b expected exclusive and idle rot",
               $time, {load_en, round_en, final_en}, rot_amt, rot_right);
    end
  endtask

  task automatic wait_ov(input string nm);
    for (int n = 0; n < 40 && !out_valid; n++) step();
    chk(nm, 32'(out_valid), 32'd1);
  endtask

  // One full operation: accept in entry 0, handshake in entry 19, IDLE in 20.
  task automatic fill_run(input int base, input logic d);
    for (int k = 0; k < 21; k++) begin
      tbl[base+k].iv   = (k == 0);
      tbl[base+k].dec  = (k == 0) ? d : ~d;
      tbl[base+k].ab   = 1'b0;
      tbl[base+k].ordy = (k == 19);
      if (k == 0 || k == 20)  tbl[base+k].exp = idle_p;
      else if (k == 1)        tbl[base+k].exp = load_p;
      else if (k <= 17)       tbl[base+k].exp = mk(0, 1, 0, 0, 0, 1, d,
                                                   d ? dec_t[k-2] : enc_t[k-2], 4'(k-2));
      else if (k == 18)       tbl[base+k].exp = mk(0, 0, 1, 0, 0, 1, 0, 2'd0, 4'd0);
      else                    tbl[base+k].exp = done_p;
    end
  endtask

  int loads [$];

  initial begin
    idle_p = mk(0, 0, 0, 0, 1, 0, 0, 2'd0, 4'd0);
    load_p = mk(1, 0, 0, 0, 0, 1, 0, 2'd0, 4'd0);
    done_p = mk(0, 0, 0, 1, 0, 1, 0, 2'd0, 4'd0);
    fill_run(0, 1'b0);
    fill_run(21, 1'b1);

    rst_n = 1'b0; in_valid = 0; in_decrypt = 0; abort = 0; out_ready = 0;
    #1;
    chk("reset_state", 32'(obs), 32'(idle_p));
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();
    chk("post_reset", 32'(obs), 32'(idle_p));

    // Table: full encrypt run then decrypt run with mode toggled after accept.
    for (int i = 0; i < 42; i++) begin
      in_valid = tbl[i].iv; in_decrypt = tbl[i].dec;
      abort = tbl[i].ab; out_ready = tbl[i].ordy;
      chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
      step();
    end
    in_valid = 0; in_decrypt = 0; out_ready = 0;

    // Backpressure: result held 10 cycles while a new request waits.
    in_valid = 1; step(); in_valid = 0;
    wait_ov("bp_wait_ov");
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold%0d", i), 32'(obs), 32'(done_p));
      step();
    end
    out_ready = 1;
    chk("bp_handshake", 32'(obs), 32'(done_p));
    step();
    out_ready = 0;
    chk("bp_idle_after", 32'(obs), 32'(idle_p));
    step();
    in_valid = 0;
    chk("bp_accept_load", 32'(obs), 32'(load_p));

    // Abort at round_idx 7, then immediate re-accept.
    for (int i = 0; i < 8; i++) step();
    chk("ab7_round", 32'(obs), 32'(mk(0, 1, 0, 0, 0, 1, 0, 2'd2, 4'd7)));
    abort = 1; step(); abort = 0;
    chk("ab7_idle", 32'(obs), 32'(idle_p));
    in_valid = 1; step(); in_valid = 0;
    chk("ab7_reaccept", 32'(obs), 32'(load_p));

    // Async reset in cycle 10 of the operation (round_idx 8).
    for (int i = 0; i < 9; i++) step();
    chk("rst_pre", 32'(obs), 32'(mk(0, 1, 0, 0, 0, 1, 0, 2'd1, 4'd8)));
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 32'(obs), 32'(idle_p));
    @(posedge clk); #2 rst_n = 1'b1;
    step();
    chk("rst_release", 32'(obs), 32'(idle_p));

    // Abort in DONE drops the result.
    in_valid = 1; step(); in_valid = 0;
    wait_ov("abd_wait_ov");
    abort = 1; step(); abort = 0;
    chk("abort_done", 32'(obs), 32'(idle_p));

    // Abort in IDLE does not block an accept; abort in LOAD cancels.
    abort = 1; in_valid = 1; step(); abort = 0; in_valid = 0;
    chk("abort_idle_accept", 32'(obs), 32'(load_p));
    abort = 1; step(); abort = 0;
    chk("abort_load", 32'(obs), 32'(idle_p));

    // Abort beats the terminal round transition (decrypt mode).
    in_valid = 1; in_decrypt = 1; step(); in_valid = 0; in_decrypt = 0;
    for (int i = 0; i < 16; i++) step();
    chk("ab15_round", 32'(obs), 32'(mk(0, 1, 0, 0, 0, 1, 1, 2'd1, 4'd15)));
    abort = 1; step(); abort = 0;
    chk("ab15_idle", 32'(obs), 32'(idle_p));

    // Back-to-back with in_valid and out_ready held: accept every 20 cycles.
    in_valid = 1; out_ready = 1;
    for (int c = 0; c < 65; c++) begin
      if (load_en) loads.push_back(c);
      step();
    end
    in_valid = 0;
    chk("b2b_count", 32'(loads.size()), 32'd4);
    for (int i = 1; i < loads.size(); i++)
      chk($sformatf("b2b_gap%0d", i), 32'(loads[i] - loads[i-1]), 32'd20);
    for (int n = 0; n < 30 && busy; n++) step();
    out_ready = 0;
    chk("final_idle", 32'(obs), 32'(idle_p));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
